instruction_fetch_unit: RTL

- Fetch stage of the RISC-V core: owns the program counter and fetches from instruction memory over a one-outstanding request/response interface.
- Holds each fetched word in an instruction register and presents it, with its opcode and PC, to decode (Immediate_Unit, control, register file) under a valid/ready handshake.
- Accepts redirects (branch/jump target) from execute.

---
 rtl/instruction_fetch_unit_if.sv | 25 ++
 rtl/instruction_fetch_unit.sv | 98 +++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus: instruction memory request/response, decode handshake and redirect.
interface instruction_fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] Instruction_bus_o;
  logic [6:0]  op_o;
  logic [31:0] pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        misaligned_o;

  modport master (
    output imem_req_o, imem_addr_o, instr_valid_o, Instruction_bus_o, op_o, pc_o, misaligned_o,
    input  imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, instr_valid_o, Instruction_bus_o, op_o, pc_o, misaligned_o,
    output imem_rvalid_i, imem_rdata_i, instr_ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// RISC-V fetch stage: owns the PC, one outstanding imem request, holds the word for decode.
// MISALIGN_CHECK_EN: misaligned redirect targets halt the fetcher instead of being force-aligned.
//
// state | meaning
// IDLE  | reset, first edge after release starts fetching
// REQ   | request strobe on imem for pc
// WAIT  | request in flight, waiting for rvalid
// HOLD  | instruction register valid, waiting for decode
// HALT  | misaligned redirect seen, only reset leaves
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic clk,
  input  logic reset,
  instruction_fetch_unit_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        discard;
  logic        misaligned;
  logic [31:0] target;
  logic        bad_target;

`ifdef MISALIGN_CHECK_EN
  assign target     = bus.redirect_pc_i;
  assign bad_target = bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00);
`else
  assign target     = {bus.redirect_pc_i[31:2], 2'b00};
  assign bad_target = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= 32'h0;
      discard    <= 1'b0;
      misaligned <= 1'b0;
    end else if (bad_target && state != HALT) begin
      misaligned <= 1'b1;
      state      <= HALT;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (bus.redirect_i) pc <= target;
        end
        REQ: begin
          state <= WAIT;
          if (bus.redirect_i) begin
            pc      <= target;
            discard <= 1'b1;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid_i) begin
            // a same-cycle redirect makes this response stale as well
            discard <= 1'b0;
            if (bus.redirect_i) pc <= target;
            if (discard || bus.redirect_i) begin
              state <= REQ;
            end else begin
              ir    <= bus.imem_rdata_i;
              state <= HOLD;
            end
          end else if (bus.redirect_i) begin
            pc      <= target;
            discard <= 1'b1;
          end
        end
        HOLD: begin
          if (bus.redirect_i) begin
            pc    <= target;
            state <= REQ;
          end else if (bus.instr_ready_i) begin
            pc    <= pc + 32'd4;
            state <= REQ;
          end
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req_o        = (state == REQ);
  assign bus.imem_addr_o       = pc;
  assign bus.instr_valid_o     = (state == HOLD);
  assign bus.Instruction_bus_o = ir;
  assign bus.op_o              = ir[6:0];
  assign bus.pc_o              = pc;
  assign bus.misaligned_o      = misaligned;

endmodule
